// File: rtl/cordic_pkg.sv
// cordic_pkg: shared constants and types for the CORDIC blocks (the
// rotation-mode cordic and the vectoring-mode cordic_vectoring).
//   ATAN_LUT       : atan(2^-i) in Q3.18, CORDIC_WIDTH+2 bits, i = 0..CORDIC_FRAC-1
//   PI_HALF_Q318   : pi/2 in Q3.18
//   INV_K_Q218     : 1/K = 0.607253 in Q2.18 (gain compensation)
//   cordic_vec_state_t : vectoring FSM states
package cordic_pkg;

   localparam int CORDIC_WIDTH = 20;
   localparam int CORDIC_FRAC  = 18;
   localparam int CORDIC_ZW    = CORDIC_WIDTH + 2;

   // round(atan(2^-i) * 2^18)
   localparam logic signed [CORDIC_ZW-1:0] ATAN_LUT [0:CORDIC_FRAC-1] = '{
      22'sd205887, 22'sd121542, 22'sd64220, 22'sd32599,
      22'sd16363,  22'sd8189,   22'sd4096,  22'sd2048,
      22'sd1024,   22'sd512,    22'sd256,   22'sd128,
      22'sd64,     22'sd32,     22'sd16,    22'sd8,
      22'sd4,      22'sd2
   };

   localparam logic signed [CORDIC_ZW-1:0] PI_HALF_Q318 = 22'sd411775;
   localparam logic [CORDIC_WIDTH-1:0]     INV_K_Q218   = 20'd159189;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ITER   = 2'd1,
      S_FINISH = 2'd2
   } cordic_vec_state_t;

endpackage

// File: rtl/cordic_vec_stage.sv
// cordic_vec_stage: one combinational vectoring micro-rotation.
// Drives y toward zero; the sign of y picks the rotation direction.
// Ports:
//   i_x, i_y, i_z : current state (signed, XW bits)
//   i_atan        : atan(2^-i) for this step, same format as i_z
//   i_shift       : iteration index i
//   o_x, o_y, o_z : next state
module cordic_vec_stage #(
   parameter int XW = 22,
   parameter int SW = 5
) (
   input  logic signed [XW-1:0] i_x,
   input  logic signed [XW-1:0] i_y,
   input  logic signed [XW-1:0] i_z,
   input  logic signed [XW-1:0] i_atan,
   input  logic        [SW-1:0] i_shift,
   output logic signed [XW-1:0] o_x,
   output logic signed [XW-1:0] o_y,
   output logic signed [XW-1:0] o_z
);

   logic signed [XW-1:0] w_xs;
   logic signed [XW-1:0] w_ys;

   // Both updates use the pre-step values.
   assign w_xs = i_x >>> i_shift;
   assign w_ys = i_y >>> i_shift;

   always_comb begin
      if (!i_y[XW-1]) begin
         o_x = i_x + w_ys;
         o_y = i_y - w_xs;
         o_z = i_z + i_atan;
      end else begin
         o_x = i_x - w_ys;
         o_y = i_y + w_xs;
         o_z = i_z - i_atan;
      end
   end

endmodule

// File: rtl/cordic_vectoring.sv
// cordic_vectoring: iterative vectoring-mode CORDIC, (X, Y) -> (angle, magnitude).
// Optional feature macro: CORDIC_GAIN_COMP_EN (when defined, MAG_O is scaled by 1/K
// in the FINISH cycle; otherwise MAG_O carries the raw CORDIC gain K).
// Ports:
//   CLK_I, RST_N_I : clock (rising edge), asynchronous active-low reset
//   READY_I        : start request, sampled only in IDLE
//   X_I, Y_I       : signed Q2.18 input vector, |X|,|Y| <= 0.5
//   BUSY_O         : high while iterating / finishing
//   DONE_O         : one-cycle pulse when ANGLE_O / MAG_O update
//   ANGLE_O        : signed Q3.17 radians, (-pi, pi]
//   MAG_O          : Q2.18 magnitude, held until the next DONE_O
module cordic_vectoring
   import cordic_pkg::*;
#(
   parameter int WIDTH = CORDIC_WIDTH,
   parameter int FRAC  = CORDIC_FRAC,
   parameter int ITER  = 16
) (
   input  logic             CLK_I,
   input  logic             RST_N_I,
   input  logic             READY_I,
   input  logic [WIDTH-1:0] X_I,
   input  logic [WIDTH-1:0] Y_I,
   output logic             BUSY_O,
   output logic             DONE_O,
   output logic [WIDTH-1:0] ANGLE_O,
   output logic [WIDTH-1:0] MAG_O
);

   localparam int XW     = WIDTH + 2;                      // two integer guard bits
   localparam int N_ITER = (ITER < FRAC) ? ITER : FRAC;    // LUT holds FRAC entries
   localparam int CW     = $clog2(N_ITER + 1);
   localparam int PW     = XW + WIDTH + 1;
   localparam logic [CW-1:0]          LAST    = CW'(N_ITER - 1);
   localparam logic signed [PW-1:0]   MAG_MAX = PW'((64'd1 << (WIDTH - 1)) - 64'd1);

   cordic_vec_state_t    r_state;
   logic [CW-1:0]        r_iter;
   logic signed [XW-1:0] r_x, r_y, r_z;
   logic                 r_zero;
   logic                 r_busy, r_done;
   logic [WIDTH-1:0]     r_angle, r_mag;

   logic signed [XW-1:0] w_x_in, w_y_in;
   logic signed [XW-1:0] w_pre_x, w_pre_y, w_pre_z;
   logic signed [XW-1:0] w_x_nx, w_y_nx, w_z_nx, w_atan;
   logic signed [PW-1:0] w_mag_full;
   logic [WIDTH-1:0]     w_mag_sat;

   assign w_x_in = XW'($signed(X_I));
   assign w_y_in = XW'($signed(Y_I));
   assign w_atan = XW'(ATAN_LUT[r_iter]);

   // Fold the left half-plane into the right so the iterations converge.
   // X<0, Y=0 takes the Y>=0 branch, giving +pi rather than -pi.
   always_comb begin
      w_pre_x = w_x_in;
      w_pre_y = w_y_in;
      w_pre_z = '0;
      if (w_x_in[XW-1]) begin
         if (!w_y_in[XW-1]) begin
            w_pre_x = w_y_in;
            w_pre_y = -w_x_in;
            w_pre_z = XW'(PI_HALF_Q318);
         end else begin
            w_pre_x = -w_y_in;
            w_pre_y = w_x_in;
            w_pre_z = -XW'(PI_HALF_Q318);
         end
      end
   end

   cordic_vec_stage #(.XW(XW), .SW(CW)) u_stage (
      .i_x     (r_x),
      .i_y     (r_y),
      .i_z     (r_z),
      .i_atan  (w_atan),
      .i_shift (r_iter),
      .o_x     (w_x_nx),
      .o_y     (w_y_nx),
      .o_z     (w_z_nx)
   );

`ifdef CORDIC_GAIN_COMP_EN
   localparam logic signed [PW-1:0] ROUND_HALF = PW'(64'd1 << (FRAC - 1));
   logic signed [PW-1:0] w_prod;
   // Full-width Q.36 product, rounded back to Q2.18.
   assign w_prod     = PW'(r_x) * PW'($signed({1'b0, INV_K_Q218}));
   assign w_mag_full = (w_prod + ROUND_HALF) >>> FRAC;
`else
   assign w_mag_full = PW'(r_x);
`endif

   // Magnitude is unsigned-valued: clamp below at 0, above at the Q2.18 max.
   always_comb begin
      if (w_mag_full[PW-1]) begin
         w_mag_sat = '0;
      end else if (w_mag_full > MAG_MAX) begin
         w_mag_sat = MAG_MAX[WIDTH-1:0];
      end else begin
         w_mag_sat = w_mag_full[WIDTH-1:0];
      end
   end

   always_ff @(posedge CLK_I or negedge RST_N_I) begin
      if (!RST_N_I) begin
         r_state <= S_IDLE;
         r_iter  <= '0;
         r_x     <= '0;
         r_y     <= '0;
         r_z     <= '0;
         r_zero  <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_angle <= '0;
         r_mag   <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (READY_I) begin
                  r_x     <= w_pre_x;
                  r_y     <= w_pre_y;
                  r_z     <= w_pre_z;
                  r_zero  <= (X_I == '0) && (Y_I == '0);
                  r_iter  <= '0;
                  r_busy  <= 1'b1;
                  r_state <= S_ITER;
               end
            end
            S_ITER: begin
               r_x <= w_x_nx;
               r_y <= w_y_nx;
               r_z <= w_z_nx;
               if (r_iter == LAST) begin
                  r_state <= S_FINISH;
               end else begin
                  r_iter <= r_iter + 1'b1;
               end
            end
            S_FINISH: begin
               // z is Q3.18; dropping its LSB gives Q3.17.
               r_angle <= r_zero ? '0 : r_z[WIDTH:1];
               r_mag   <= r_zero ? '0 : w_mag_sat;
               r_done  <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign BUSY_O  = r_busy;
   assign DONE_O  = r_done;
   assign ANGLE_O = r_angle;
   assign MAG_O   = r_mag;

endmodule

// File: tb/tb_cordic_vectoring.sv
// tb_cordic_vectoring: scoreboard bench for cordic_vectoring.
// The driver pushes the ideal atan2 / hypot result (real arithmetic) for each
// capture; a monitor pops and compares on every DONE_O, including its cycle.
module tb_cordic_vectoring;

   localparam int WIDTH = 20;
   localparam int FRAC  = 18;
   localparam int ITER  = 16;

   // Directed vectors use the nominal tolerances. Random vectors (magnitude
   // 0.375..0.707) get some extra room for the worst-case combination of the
   // final-step residual angle and shift truncation.
   localparam int TOL_A  = 4;
   localparam int TOL_M  = 8;
   localparam int RTOL_A = 8;
   localparam int RTOL_M = 12;

   logic             CLK_I;
   logic             RST_N_I;
   logic             READY_I;
   logic [WIDTH-1:0] X_I, Y_I;
   logic             BUSY_O, DONE_O;
   logic [WIDTH-1:0] ANGLE_O, MAG_O;

   typedef struct {
      logic [WIDTH-1:0] x;
      logic [WIDTH-1:0] y;
      int ang;
      int mag;
      int tol_a;
      int tol_m;
      int done_cyc;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   cyc    = 0;
   int   n_chk  = 0;
   int   n_err  = 0;
   int   n_op   = 0;

   cordic_vectoring #(.WIDTH(WIDTH), .FRAC(FRAC), .ITER(ITER)) dut (
      .CLK_I   (CLK_I),
      .RST_N_I (RST_N_I),
      .READY_I (READY_I),
      .X_I     (X_I),
      .Y_I     (Y_I),
      .BUSY_O  (BUSY_O),
      .DONE_O  (DONE_O),
      .ANGLE_O (ANGLE_O),
      .MAG_O   (MAG_O)
   );

   initial CLK_I = 1'b0;
   always #5 CLK_I = ~CLK_I;

   always @(posedge CLK_I) cyc <= cyc + 1;

   function automatic int rnd(input real v);
      if (v >= 0.0) return $rtoi(v + 0.5);
      return -$rtoi(-v + 0.5);
   endfunction

   // Ideal polar result of a Q2.18 vector, in the output formats.
   function automatic void model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                 output int ang, output int mag);
      int  xi, yi;
      real xr, yr, k, p, m;
      xi = $signed(x);
      yi = $signed(y);
      if (xi == 0 && yi == 0) begin
         ang = 0;
         mag = 0;
         return;
      end
      xr  = $itor(xi) / 262144.0;
      yr  = $itor(yi) / 262144.0;
      ang = rnd($atan2(yr, xr) * 131072.0);
      k = 1.0;
      p = 1.0;
      for (int i = 0; i < ITER; i++) begin
         k = k * $sqrt(1.0 + p);
         p = p / 4.0;
      end
`ifdef CORDIC_GAIN_COMP_EN
      k = 1.0;
`endif
      m   = $sqrt(xr * xr + yr * yr) * k * 262144.0;
      mag = rnd(m);
      if (mag > 524287) mag = 524287;
   endfunction

   task automatic chk(input string name, input int act, input int req, input int diff, input int tol);
      n_chk++;
      if (diff > tol || diff < -tol) begin
         n_err++;
         $display("FAIL %s: got %0d, want %0d (tol %0d) at cycle %0d", name, act, req, tol, cyc);
      end
   endtask

   // Monitor: every DONE_O must match the oldest outstanding capture.
   always @(negedge CLK_I) begin
      if (DONE_O) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_done", 1, 0, 1, 0);
         end else begin
            logic [WIDTH-1:0] dd;
            int d;
            mon_e = exp_q.pop_front();
            n_op++;
            $display("op %0d X=%h Y=%h ANGLE=%h MAG=%h exp_angle=%0d exp_mag=%0d cycle=%0d",
                     n_op, mon_e.x, mon_e.y, ANGLE_O, MAG_O, mon_e.ang, mon_e.mag, cyc);
            chk("done_cycle", cyc, mon_e.done_cyc, cyc - mon_e.done_cyc, 0);
            dd = ANGLE_O - mon_e.ang[WIDTH-1:0];
            d  = $signed(dd);
            chk("angle", $signed(ANGLE_O), mon_e.ang, d, mon_e.tol_a);
            chk("mag", int'({12'd0, MAG_O}), mon_e.mag, int'({12'd0, MAG_O}) - mon_e.mag, mon_e.tol_m);
         end
      end
   end

   // Called at a negedge while the DUT is idle; returns at the negedge on which
   // the result is visible (the next capture may be set up right there).
   task automatic do_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                        input bit hold, input int tol_a, input int tol_m);
      exp_t e;
      int   a, m;
      model(x, y, a, m);
      e.x = x; e.y = y; e.ang = a; e.mag = m; e.tol_a = tol_a; e.tol_m = tol_m;
      e.done_cyc = cyc + ITER + 2;
      exp_q.push_back(e);
      READY_I = 1'b1;
      X_I = x;
      Y_I = y;
      @(negedge CLK_I);
      chk("busy_after_capture", int'(BUSY_O), 1, int'(BUSY_O) - 1, 0);
      repeat (ITER + 1) begin
         READY_I = hold;
         X_I = WIDTH'($urandom);
         Y_I = WIDTH'($urandom);
         @(negedge CLK_I);
      end
      chk("busy_at_done", int'(BUSY_O), 0, int'(BUSY_O), 0);
   endtask

   task automatic gen_vec(output logic [WIDTH-1:0] x, output logic [WIDTH-1:0] y);
      longint xi, yi;
      do begin
         xi = longint'($urandom_range(0, 262144)) - 131072;
         yi = longint'($urandom_range(0, 262144)) - 131072;
      end while (xi * xi + yi * yi < 64'd9663676416);
      x = xi[WIDTH-1:0];
      y = yi[WIDTH-1:0];
   endtask

   task automatic check_zero_outputs(input string tag);
      chk({tag, "_busy"},  int'(BUSY_O),  0, int'(BUSY_O),  0);
      chk({tag, "_done"},  int'(DONE_O),  0, int'(DONE_O),  0);
      chk({tag, "_angle"}, int'(ANGLE_O), 0, int'(ANGLE_O), 0);
      chk({tag, "_mag"},   int'(MAG_O),   0, int'(MAG_O),   0);
   endtask

   initial begin
      logic [WIDTH-1:0] rx, ry;
      RST_N_I = 1'b0;
      READY_I = 1'b0;
      X_I = '0;
      Y_I = '0;
      repeat (3) @(negedge CLK_I);
      check_zero_outputs("reset");
      RST_N_I = 1'b1;
      @(negedge CLK_I);

      // Directed corner vectors.
      do_op(20'h20000, 20'h00000, 1'b0, TOL_A, TOL_M);
      do_op(20'h1BB68, 20'h10000, 1'b0, TOL_A, TOL_M);
      READY_I = 1'b0;
      repeat (2) @(negedge CLK_I);
      do_op(20'hE0000, 20'h00000, 1'b0, TOL_A, TOL_M);
      do_op(20'h00000, 20'hE0000, 1'b0, TOL_A, TOL_M);
      do_op(20'h00000, 20'h00000, 1'b0, 0, 0);

      // Random vectors with random idle gaps.
      for (int k = 0; k < 12; k++) begin
         gen_vec(rx, ry);
         do_op(rx, ry, 1'b0, RTOL_A, RTOL_M);
         READY_I = 1'b0;
         repeat ($urandom_range(0, 3)) @(negedge CLK_I);
      end

      // READY held high: back-to-back with inputs scrambled mid-computation.
      for (int k = 0; k < 5; k++) begin
         gen_vec(rx, ry);
         do_op(rx, ry, 1'b1, RTOL_A, RTOL_M);
      end
      READY_I = 1'b0;
      @(negedge CLK_I);

      // Abort at iteration 8 with an asynchronous reset in mid-cycle.
      gen_vec(rx, ry);
      READY_I = 1'b1;
      X_I = rx;
      Y_I = ry;
      @(negedge CLK_I);
      READY_I = 1'b0;
      repeat (8) @(negedge CLK_I);
      #2 RST_N_I = 1'b0;
      #1 check_zero_outputs("async_reset");
      repeat (2) @(negedge CLK_I);
      RST_N_I = 1'b1;
      gen_vec(rx, ry);
      do_op(rx, ry, 1'b0, RTOL_A, RTOL_M);
      READY_I = 1'b0;

      repeat (4) @(negedge CLK_I);
      chk("pending_results", exp_q.size(), 0, exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, cycle=%0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/cordic_vectoring.md
# cordic_vectoring

Iterative vectoring-mode CORDIC: takes a Cartesian vector (X, Y) and returns its angle (atan2) and magnitude. It is the inverse of the rotation-mode `cordic` sin/cos block and uses the same fixed-point angle convention and READY/DONE handshake. The two blocks together form a polar↔Cartesian pair in the course-work datapath.

## Interface
- `WIDTH`, 20: data width of X/Y/MAG/ANGLE.
- `FRAC`, 18: fractional bits of X, Y and MAG (Q2.18).
- `ITER`, 16: number of micro-rotations, 1..`FRAC`.
- `CLK_I` in 1: the single clock, rising edge.
- `RST_N_I` in 1: reset, asynchronous and active-low.
- `READY_I` in 1: request; sampled only in IDLE.
- `X_I` in `WIDTH`: signed Q2.18 X; must satisfy |X| ≤ 0.5 (0x20000).
- `Y_I` in `WIDTH`: signed Q2.18 Y; must satisfy |Y| ≤ 0.5.
- `BUSY_O` out 1: high in ITER and FINISH.
- `DONE_O` out 1: one-cycle pulse when results update.
- `ANGLE_O` out `WIDTH`: signed Q3.17 radians, range (−π, π].
- `MAG_O` out `WIDTH`: unsigned-valued Q2.18 magnitude, held until the next DONE_O.

## Operation
- States:
  - IDLE: if `READY_I`=1, capture inputs, pre-rotate, counter i=0, go to ITER.
  - ITER: one micro-rotation per cycle. After i=`ITER`−1, go to FINISH.
  - FINISH: register outputs, pulse `DONE_O`, go to IDLE.
- Internal X/Y use `WIDTH`+2 bits (guard bits). The angle accumulator z is `WIDTH`+2 bits, Q3.18.
- Pre-rotation:
  - X≥0: (x, y, z) = (X, Y, 0).
  - X<0, Y≥0: (Y, −X, +π/2).
  - X<0, Y<0: (−Y, X, −π/2).
  - Consequence: X<0, Y=0 yields +π.
- Micro-rotation i:
  - y≥0: x += y>>>i; y −= x>>>i; z += atan(2^−i).
  - y<0: x −= y>>>i; y += x>>>i; z −= atan(2^−i).
  - Both x and y updates use the old values. Shifts are arithmetic.
- Outputs:
  - `ANGLE_O` = z>>>1, truncated to `WIDTH`.
  - `MAG_O` = x, scaled per Configuration. Saturates to 0x7FFFF if it exceeds the positive range.
- Zero vector (X=Y=0): a flag captured in IDLE forces `ANGLE_O`=0 and `MAG_O`=0. Latency is unchanged.
- `READY_I` is ignored while BUSY. Inputs are sampled only at the capture edge, so later changes to `X_I`/`Y_I` have no effect.
- Out-of-range inputs: results are unspecified, but outputs are never X and no lock-up occurs.

## Timing
- Reset (async assert): state IDLE; `BUSY_O`=0, `DONE_O`=0, `ANGLE_O`=0, `MAG_O`=0; counter cleared.
- Reset mid-operation aborts the computation immediately; old results are not retained.
- Capture edge E0 (IDLE, `READY_I`=1). Iterations occur on edges E1..E`ITER`. FINISH is at edge E`ITER`+1, so `DONE_O`=1 for the cycle following E`ITER`+1.
- Latency is `ITER`+1 edges; with default 16, `DONE_O` rises 17 cycles after capture.
- `READY_I` held high: back-to-back operations, one `DONE_O` every `ITER`+2 cycles (18 by default). The recapture edge is the same edge on which `DONE_O` falls.
- `BUSY_O` is high from after E0 until after E`ITER`+1.
- The outputs and `DONE_O` change on the same edge.

## Configuration
- `CORDIC_GAIN_COMP_EN` defined:
  - `MAG_O` = x·INV_K, where INV_K = 0.607253 in Q2.18 = 159189.
  - The multiply is done in FINISH with a full-width product, rounded to Q2.18.
  - Latency is unchanged.
- `CORDIC_GAIN_COMP_EN` undefined:
  - `MAG_O` = x unscaled, i.e. true magnitude × K ≈ 1.64676.
  - No multiplier is instantiated.

## Structure
- Package `cordic_pkg` holds:
  - `ATAN_LUT[0:FRAC-1]`, Q3.18, `WIDTH`+2 bits.
  - `PI_HALF_Q318`.
  - `INV_K_Q218` = 159189.
  - The state enum `cordic_vec_state_t` (IDLE/ITER/FINISH).
  - The `ATAN_LUT` is shared with `cordic`.
- One sub-module `cordic_vec_stage`: combinational single micro-rotation (x, y, z, i, atan_i → x', y', z'). The top holds the FSM, counter, pre-rotation and output registers.

## Test plan
Tolerances: angle ±4 LSB, magnitude ±8 LSB; results are checked at `DONE_O`.
- X=0x20000, Y=0:
  - `ANGLE_O`=0.
  - With comp: `MAG_O`=0x20000. Without comp: 0x34B25.
  - `DONE_O` is observed exactly 17 cycles after capture.
- X=0x1BB68, Y=0x10000 (0.5∠30°) → `ANGLE_O`=0x10C15, `MAG_O`=0x20000 (comp on).
- X=0xE0000 (−0.5), Y=0 → `ANGLE_O`=0x6487F (+π), `MAG_O`=0x20000.
- X=0, Y=0xE0000 → `ANGLE_O`=0xCDBC0 (−π/2). Then X=Y=0 → `ANGLE_O`=0, `MAG_O`=0.
- `READY_I` held high with inputs changed mid-computation:
  - `DONE_O` pulses every 18 cycles.
  - Each result matches the inputs present at its own capture edge.
- Assert `RST_N_I`=0 at iteration 8:
  - All outputs are 0 asynchronously and the state is IDLE.
  - After release with `READY_I`=1, a fresh result appears 17 cycles after capture, with no stale `DONE_O`.
